mc10181_alu: RTL and testbench
==============================

Name: mc10181_alu

Overview:
- 4-bit ECL-style ALU slice, functionally equivalent to the MC10181.
- Supports 16 arithmetic functions (mode low) and 16 Boolean functions (mode high).
- Provides group carry-generate and carry-propagate outputs for lookahead, plus a ripple carry-out.
- Used as a datapath slice in wider ALUs; the outputs are optionally registered.

Parameters:
REGISTERED, 0, 0 = outputs combinational (clk/rst_n ignored); 1 = outputs captured by one register stage.

Ports:
clk  input  1  rising-edge clock, used only when REGISTERED=1
rst_n  input  1  asynchronous active-low reset
s0,s1,s2,s3  input  1 each  function select; s0 is LSB of the select code
boole  input  1  mode: 1 = logic, 0 = arithmetic
cin  input  1  active-high carry-in to bit 0
a0..a3  input  1 each  operand A; a0 = LSB
b0..b3  input  1 each  operand B; b0 = LSB
f0..f3  output  1 each  function result; f0 = LSB
cg  output  1  group carry generate, active high
cp  output  1  group carry propagate, active high
cout  output  1  carry out of bit 3, active high

Behaviour:
- Vectors below are written MSB-first: S = s3s2s1s0, A = a3..a0.
- Per-bit terms, i = 0..3:
  - g_i = (A_i & B_i & s3) | (A_i & ~B_i & s2)
  - p_i = A_i | (B_i & s0) | (~B_i & s1)
  - h_i = p_i ^ g_i
- Ripple carries: c_0 = cin; c_(i+1) = g_i | (p_i & c_i).
- Arithmetic mode (boole=0): F_i = h_i ^ c_i. Key codes:
  - S=0000: F = A + cin
  - S=1001: F = A + B + cin
  - S=0110: F = A + ~B + cin (A minus B when cin=1)
  - S=1111: F = A - 1 + cin
- Logic mode (boole=1): F_i = ~h_i; the carry is ignored. Key codes:
  - S=0000: F = ~A
  - S=1001: F = A xnor B
  - S=0110: F = A xor B
- cp = p0 & p1 & p2 & p3.
- cg = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- cout = cg | (cp & cin).
- cg, cp and cout are computed in both modes.
- Arithmetic wraps modulo 16; overflow is visible only via cout.
- REGISTERED=0:
  - Pure combinational, zero cycles latency.
  - No internal state; clk and rst_n have no effect.
- REGISTERED=1:
  - f, cg, cp and cout are captured on every rising clk; latency 1 cycle, no enable or handshake.
  - While rst_n=0, all outputs are 0, asynchronously and immediately, including mid-operation.
  - The first capture occurs on the first rising clk after rst_n goes high.
- Unknown or X inputs propagate; there is no special handling.

Decomposition:
- Shared package: ALU select-code constants (ALU_A=4'b0000, ALU_ADD=4'b1001, ALU_SUB=4'b0110, ALU_DEC=4'b1111) and a mode enum (ARITH=0, LOGIC=1).
- One natural sub-module, mc10181_bit: one bit slice producing g_i, p_i and h_i.
- The top level handles:
  - the carry chain
  - group cg/cp/cout
  - mode muxing
  - the optional register stage

Test Plan:
- boole=0, S=0000, cin=0, A=1111, B=0000 -> F=1111, cg=0, cp=1, cout=0. With cin=1 -> F=0000, cout=1.
- boole=0, S=1001, cin=0:
  - A=0101, B=0011 -> F=1000, cg=0, cp=0, cout=0.
  - A=1111, B=0001 -> F=0000, cg=1, cp=1, cout=1.
- boole=0, S=0110, cin=1, A=0111, B=0010 -> F=0101, cout=1 (no borrow).
- boole=1, S=0110, A=1010, B=0110 -> F=1100. boole=1, S=0000, A=1010 -> F=0101 regardless of cin.
- REGISTERED=1 reset and latency:
  - Hold rst_n=0 -> F=0000, cg=cp=cout=0.
  - Release, apply the A=1111, B=0001 add -> outputs update only after the next rising clk.
  - Assert rst_n mid-stream -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/mc10181_alu_pkg.sv
// Shared definitions for the MC10181-style 4-bit ALU slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: select-code constants, mode enum, packed result bundle.
package mc10181_alu_pkg;

    // Select codes (S = s3 s2 s1 s0) for the most commonly used functions.
    localparam logic [3:0] ALU_A   = 4'b0000;  // arith: A + cin,      logic: ~A
    localparam logic [3:0] ALU_ADD = 4'b1001;  // arith: A + B + cin,  logic: A xnor B
    localparam logic [3:0] ALU_SUB = 4'b0110;  // arith: A + ~B + cin, logic: A xor B
    localparam logic [3:0] ALU_DEC = 4'b1111;  // arith: A - 1 + cin

    typedef enum logic {
        ARITH = 1'b0,
        LOGIC = 1'b1
    } mode_e;

    // Everything the slice presents on its outputs, bundled so the optional
    // register stage captures it as one word.
    typedef struct packed {
        logic [3:0] f;
        logic       cg;
        logic       cp;
        logic       cout;
    } result_t;

endpackage

// File: rtl/mc10181_alu_if.sv
// Operand/select/result bundle of one 4-bit ALU slice.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-valued every cycle.
// Ports: s0..s3 select, boole mode, cin, a0..a3, b0..b3 in; f0..f3, cg, cp, cout out.
interface mc10181_alu_if;

    logic s0, s1, s2, s3;
    logic boole;
    logic cin;
    logic a0, a1, a2, a3;
    logic b0, b1, b2, b3;
    logic f0, f1, f2, f3;
    logic cg;
    logic cp;
    logic cout;

    // Driver side: supplies operands and select, observes results.
    modport master (
        output s0, s1, s2, s3, boole, cin,
        output a0, a1, a2, a3, b0, b1, b2, b3,
        input  f0, f1, f2, f3, cg, cp, cout
    );

    // ALU side.
    modport slave (
        input  s0, s1, s2, s3, boole, cin,
        input  a0, a1, a2, a3, b0, b1, b2, b3,
        output f0, f1, f2, f3, cg, cp, cout
    );

endinterface

// File: rtl/mc10181_alu_bit.sv
// One bit slice of the ALU: generate, propagate and half-sum terms.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operand bits; sel 4-bit function select; g, p, h per-bit terms.
module mc10181_bit (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] sel,
    output logic       g,
    output logic       p,
    output logic       h
);

    // The select bits choose which of A&B / A&~B generate and which of
    // B / ~B propagate, so one structure covers all 16 functions.
    assign g = (a & b & sel[3]) | (a & ~b & sel[2]);
    assign p = a | (b & sel[0]) | (~b & sel[1]);
    assign h = p ^ g;

endmodule

// File: rtl/mc10181_alu.sv
// MC10181-equivalent 4-bit ALU slice: 16 arithmetic + 16 logic functions, lookahead cg/cp, ripple cout.
// Latency: 0 cycles when REGISTERED=0, 1 cycle when REGISTERED=1 (async active-low clear).
// Backpressure: none; a new result is produced for every input set / every clock.
// Ports: clk, rst_n (used only when REGISTERED=1); bus = slave side of mc10181_alu_if.
module mc10181_alu #(
    parameter bit REGISTERED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    mc10181_alu_if.slave       bus
);

    import mc10181_alu_pkg::*;

    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] h;
    logic [3:0] c;
    logic [3:0] f;
    logic       cg;
    logic       cp;
    logic       cout;
    mode_e      mode;
    result_t    comb_res;
    result_t    out_res;

    assign sel  = {bus.s3, bus.s2, bus.s1, bus.s0};
    assign a    = {bus.a3, bus.a2, bus.a1, bus.a0};
    assign b    = {bus.b3, bus.b2, bus.b1, bus.b0};
    assign mode = mode_e'(bus.boole);

    for (genvar i = 0; i < 4; i++) begin : g_bit
        mc10181_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .g   (g[i]),
            .p   (p[i]),
            .h   (h[i])
        );
    end

    // Ripple carry into each bit; the carry out of bit 3 comes from the
    // lookahead terms below instead, which is logically the same value.
    always_comb begin
        c    = '0;
        c[0] = bus.cin;
        for (int k = 0; k < 3; k++) begin
            c[k + 1] = g[k] | (p[k] & c[k]);
        end
    end

    // Logic mode ignores the carry entirely.
    assign f = (mode == LOGIC) ? ~h : (h ^ c);

    // Group terms are produced in both modes so a lookahead unit upstream
    // never sees them change meaning with boole.
    assign cp   = &p;
    assign cg   = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cout = cg | (cp & bus.cin);

    assign comb_res = '{f: f, cg: cg, cp: cp, cout: cout};

    if (REGISTERED) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_res <= '0;
            end else begin
                out_res <= comb_res;
            end
        end
    end else begin : g_comb
        // Clock and reset are deliberately left unconnected in this variant.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_res        = comb_res;
    end

    assign bus.f0   = out_res.f[0];
    assign bus.f1   = out_res.f[1];
    assign bus.f2   = out_res.f[2];
    assign bus.f3   = out_res.f[3];
    assign bus.cg   = out_res.cg;
    assign bus.cp   = out_res.cp;
    assign bus.cout = out_res.cout;

endmodule

// File: tb/tb_mc10181_alu.sv
// Directed testbench for mc10181_alu: combinational and registered variants side by side.
// Latency: checks 0-cycle comb results and 1-cycle registered results.
// Backpressure: n/a.
module tb_mc10181_alu;

    import mc10181_alu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mc10181_alu_if ic ();
    mc10181_alu_if ir ();

    mc10181_alu #(.REGISTERED(1'b0)) u_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ic)
    );

    mc10181_alu #(.REGISTERED(1'b1)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same stimulus to both instances.
    task automatic drive(input logic md, input logic [3:0] s, input logic ci,
                         input logic [3:0] av, input logic [3:0] bv);
        {ic.s3, ic.s2, ic.s1, ic.s0} = s;
        {ir.s3, ir.s2, ir.s1, ir.s0} = s;
        ic.boole = md;
        ir.boole = md;
        ic.cin   = ci;
        ir.cin   = ci;
        {ic.a3, ic.a2, ic.a1, ic.a0} = av;
        {ir.a3, ir.a2, ir.a1, ir.a0} = av;
        {ic.b3, ic.b2, ic.b1, ic.b0} = bv;
        {ir.b3, ir.b2, ir.b1, ir.b0} = bv;
    endtask

    // Observed words are {F[3:0], cg, cp, cout}.
    function automatic logic [6:0] obs_comb();
        return {ic.f3, ic.f2, ic.f1, ic.f0, ic.cg, ic.cp, ic.cout};
    endfunction

    function automatic logic [6:0] obs_reg();
        return {ir.f3, ir.f2, ir.f1, ir.f0, ir.cg, ir.cp, ir.cout};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed F/cg/cp/cout=%b_%b expected=%b_%b",
                   tag, obs[6:3], obs[2:0], exp[6:3], exp[2:0]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;

        // Reset held: registered copy stays clear while comb copy computes.
        drive(ARITH, ALU_A, 1'b0, 4'b1111, 4'b0000);
        #1;
        chk("reset_reg",       obs_reg(),  7'b0000_000);
        chk("arith_a_cin0",    obs_comb(), 7'b1111_010);

        drive(ARITH, ALU_A, 1'b1, 4'b1111, 4'b0000);
        #1 chk("arith_a_cin1",   obs_comb(), 7'b0000_011);

        drive(ARITH, ALU_ADD, 1'b0, 4'b0101, 4'b0011);
        #1 chk("add_5_3",        obs_comb(), 7'b1000_000);

        drive(ARITH, ALU_ADD, 1'b0, 4'b1111, 4'b0001);
        #1 chk("add_wrap",       obs_comb(), 7'b0000_111);

        drive(ARITH, ALU_SUB, 1'b1, 4'b0111, 4'b0010);
        #1 chk("sub_7_2",        obs_comb(), 7'b0101_111);

        drive(ARITH, ALU_DEC, 1'b0, 4'b0000, 4'b0000);
        #1 chk("dec_0",          obs_comb(), 7'b1111_010);

        drive(ARITH, ALU_DEC, 1'b0, 4'b1000, 4'b0000);
        #1 chk("dec_8",          obs_comb(), 7'b0111_111);

        drive(LOGIC, ALU_SUB, 1'b0, 4'b1010, 4'b0110);
        #1 chk("logic_xor",      obs_comb(), 7'b1100_101);

        drive(LOGIC, ALU_A, 1'b0, 4'b1010, 4'b0000);
        #1 chk("logic_nota_c0",  obs_comb(), 7'b0101_000);

        drive(LOGIC, ALU_A, 1'b1, 4'b1010, 4'b0000);
        #1 chk("logic_nota_c1",  obs_comb(), 7'b0101_000);

        drive(LOGIC, ALU_ADD, 1'b0, 4'b1010, 4'b0110);
        #1 chk("logic_xnor",     obs_comb(), 7'b0011_101);

        // Clock edges under reset must not load the register.
        @(posedge clk);
        @(posedge clk);
        #1 chk("reset_hold_clk", obs_reg(),  7'b0000_000);

        // Release reset and present the wrapping add away from the edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(ARITH, ALU_ADD, 1'b0, 4'b1111, 4'b0001);
        #1 chk("reg_before_edge", obs_reg(), 7'b0000_000);
        @(posedge clk);
        #1 chk("reg_add_wrap",    obs_reg(), 7'b0000_111);

        @(negedge clk);
        drive(ARITH, ALU_ADD, 1'b0, 4'b0101, 4'b0011);
        #1 chk("reg_hold_prev",   obs_reg(), 7'b0000_111);
        @(posedge clk);
        #1 chk("reg_add_5_3",     obs_reg(), 7'b1000_000);

        @(negedge clk);
        drive(ARITH, ALU_SUB, 1'b1, 4'b0111, 4'b0010);
        @(posedge clk);
        #1 chk("reg_sub_7_2",     obs_reg(), 7'b0101_111);

        // Mid-stream reset clears immediately, no edge required.
        #2 rst_n = 1'b0;
        #1 chk("reg_async_clear", obs_reg(),  7'b0000_000);
        chk("comb_ignores_rst",   obs_comb(), 7'b0101_111);
        @(posedge clk);
        #1 chk("reg_clear_hold",  obs_reg(),  7'b0000_000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
